// File: rtl/rv32_types.sv
// Shared types for the RV32 memory arbiter: FSM states, request owner,
// and the captured memory-request record with its reset value and
// fetch constructor.
package rv32_types;

  // Widest address/data the request record can carry; the arbiter's
  // ADDR_W/DATA_W parameters must not exceed these.
  localparam int unsigned RV_ADDR_W = 32;
  localparam int unsigned RV_DATA_W = 32;
  localparam int unsigned RV_BE_W   = RV_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                 we;
    logic [RV_BE_W-1:0]   be;
    logic [RV_ADDR_W-1:0] addr;
    logic [RV_DATA_W-1:0] wdata;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_RESET = '{
    we:    1'b0,
    be:    {RV_BE_W{1'b0}},
    addr:  {RV_ADDR_W{1'b0}},
    wdata: {RV_DATA_W{1'b0}}
  };

  // A fetch is always a full-word read with no write data.
  function automatic mem_req_t fetch_req(input logic [RV_ADDR_W-1:0] addr);
    mem_req_t r;
    r.we    = 1'b0;
    r.be    = {RV_BE_W{1'b1}};
    r.addr  = addr;
    r.wdata = {RV_DATA_W{1'b0}};
    return r;
  endfunction

endpackage

// File: rtl/rv32_mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a
// single-port memory. One transaction in flight; data has priority
// unless a waiting fetch has been passed over STARVE_LIMIT times.
module rv32_mem_arbiter
  import rv32_types::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned    BE_W    = DATA_W / 8;
  localparam int unsigned    CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  mem_req_t         req_q, req_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             fetch_win_s, data_win_s, rsp_s;

  // Pick the winner in IDLE; grants are suppressed while reset is held.
  always_comb begin
    fetch_win_s = 1'b0;
    data_win_s  = 1'b0;
    if ((state_q == ST_IDLE) && resetn) begin
      if (if_req && (!d_req || (starve_q == CNT_MAX))) begin
        fetch_win_s = 1'b1;
      end else if (d_req) begin
        data_win_s = 1'b1;
      end else begin
        fetch_win_s = 1'b0;
        data_win_s  = 1'b0;
      end
    end else begin
      fetch_win_s = 1'b0;
      data_win_s  = 1'b0;
    end
  end

  assign if_gnt = fetch_win_s;
  assign d_gnt  = data_win_s;

  // Next-state, request capture and starvation bookkeeping.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    req_d    = req_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_win_s) begin
          owner_d  = OWN_FETCH;
          req_d    = fetch_req(RV_ADDR_W'(if_addr));
          starve_d = {CNT_W{1'b0}};
          state_d  = ST_REQ;
        end else if (data_win_s) begin
          owner_d     = OWN_DATA;
          req_d.we    = d_we;
          req_d.be    = RV_BE_W'(d_be);
          req_d.addr  = RV_ADDR_W'(d_addr);
          req_d.wdata = RV_DATA_W'(d_wdata);
          state_d     = ST_REQ;
          // only count data grants that actually made a fetch wait
          if (if_req && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1'b1);
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d = ST_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, owner, captured request and starve counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_FETCH;
      req_q    <= MEM_REQ_RESET;
      starve_q <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      starve_q <= starve_d;
    end
  end

  // Memory request fields come straight from registers.
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = req_q.we;
  assign mem_be    = BE_W'(req_q.be);
  assign mem_addr  = ADDR_W'(req_q.addr);
  assign mem_wdata = DATA_W'(req_q.wdata);

  // Route the memory response to its owner only; rdata is zero otherwise.
  always_comb begin
    rsp_s     = (state_q == ST_RSP) && mem_rvalid;
    if_rvalid = rsp_s && (owner_q == OWN_FETCH);
    d_rvalid  = rsp_s && (owner_q == OWN_DATA);
    if (if_rvalid) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = {DATA_W{1'b0}};
    end
    if (d_rvalid) begin
      d_rdata = mem_rdata;
    end else begin
      d_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: doc/rv32_mem_arbiter.md
RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, shall set the address width of all ports.
REQ-002 Parameter DATA_W, default 32, shall set the data width of all ports; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_LIMIT, default 4, shall set the maximum number of consecutive data grants while a fetch waits.
REQ-004 Clocking shall be one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 if_req  in  1  fetch read request; if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  fetch request captured; if_rvalid  out  1  fetch data valid; if_rdata  out  DATA_W.
REQ-009 d_req  in  1  data request; d_we  in  1  write; d_be  in  DATA_W/8  byte enables; d_addr  in  ADDR_W; d_wdata  in  DATA_W.
REQ-010 d_gnt  out  1  data request captured; d_rvalid  out  1  response (read or write); d_rdata  out  DATA_W.
REQ-011 mem_req, mem_we  out  1; mem_be  out  DATA_W/8; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W: single-port memory request.
REQ-012 mem_gnt  in  1  memory accepted request; mem_rvalid  in  1  response; mem_rdata  in  DATA_W.

Function
REQ-013 States: IDLE, REQ, RSP; at most one transaction in flight.
REQ-014 IDLE: if any requester asserts req, select winner, pulse its gnt combinationally that cycle, register its fields into mem_* and owner, go REQ.
REQ-015 Fetch requests shall drive mem_we=0, mem_be=all ones, mem_wdata=0.
REQ-016 Priority: data wins unless starve counter == STARVE_LIMIT with if_req high, then fetch wins.
REQ-017 Starve counter shall increment on each data grant while if_req is high, clear on any fetch grant, and saturate at STARVE_LIMIT.
REQ-018 REQ: mem_req=1 with registered fields held stable; on mem_gnt go RSP, same edge clearing mem_req.
REQ-019 RSP: on mem_rvalid drive owner's rvalid=1 and rdata=mem_rdata combinationally that cycle, go IDLE.
REQ-020 Non-owner rvalid shall be 0; rdata outputs shall be 0 when their rvalid is 0.
REQ-021 mem_rvalid outside RSP and mem_gnt outside REQ shall be ignored.
REQ-022 Minimum latency: req at cycle N, gnt at N, mem_req at N+1; with mem_gnt at N+1 and mem_rvalid at N+2, rvalid at N+2.
REQ-023 Next grant shall not occur before the cycle after rvalid (IDLE re-entered); back-to-back throughput one transaction per 3 cycles minimum.
REQ-024 Simultaneous if_req and d_req in IDLE shall grant exactly one; requester not granted keeps req high and is not acknowledged.
REQ-025 Requesters may drop or change req/address after gnt; captured values shall be unaffected.

Reset
REQ-026 resetn low shall asynchronously force IDLE, starve counter 0, owner fetch, all outputs 0.
REQ-027 Reset mid-transaction shall abandon it; any later mem_rvalid shall be ignored until a new REQ->RSP sequence.

Structure
REQ-028 State enum, owner enum and a memory-request struct (we, be, addr, wdata) shall live in the shared rv32_types package.
REQ-029 No sub-module; single module with one state register, one request register, one counter.

Verification
REQ-030 Data read alone: d_req, d_addr=0x100, mem_gnt at once, mem_rdata=0xDEADBEEF next cycle -> d_gnt cycle 0, mem_addr=0x100 cycle 1, d_rvalid/d_rdata=0xDEADBEEF cycle 2.
REQ-031 Simultaneous if_req/d_req from idle -> data granted first, fetch granted in the IDLE cycle after d_rvalid.
REQ-032 if_req held, d_req held continuously, STARVE_LIMIT=4 -> four data grants, then fetch grant, counter 0.
REQ-033 Write d_we=1, d_be=0x3, d_wdata=0x1234, mem_gnt delayed 3 cycles -> mem_* stable 4 cycles, d_rvalid after mem_rvalid.
REQ-034 resetn low during RSP, stray mem_rvalid after release -> no rvalid asserted, state IDLE, outputs 0.
